// File: rtl/inst_fetch.sv
// Instruction fetch: assembles a 32-bit instruction from four little-endian byte
// reads on the shared memory port and holds it at the IF/ID boundary until taken.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic        inst_ready_i,
    input  logic        mem_grant_i,
    input  logic [7:0]  mem_din_i,
    output logic        mem_req_o,
    output logic [31:0] mem_a_o,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o
);

    localparam logic [0:0] FETCH = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

    logic [0:0]  state;
    logic [31:0] pc;
    logic [2:0]  issue_cnt;
    logic [1:0]  recv_cnt;
    logic        pending;
    logic [7:0]  byte0, byte1, byte2;

    // Request/address come only from registered state, never from inst_ready_i.
    assign mem_req_o = (state == FETCH) && (issue_cnt < 3'd4);
    assign mem_a_o   = (state == FETCH) ? pc + {29'd0, issue_cnt} : pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= FETCH;
            pc           <= RESET_PC;
            issue_cnt    <= 3'd0;
            recv_cnt     <= 2'd0;
            pending      <= 1'b0;
            byte0        <= 8'd0;
            byte1        <= 8'd0;
            byte2        <= 8'd0;
            inst_valid_o <= 1'b0;
            inst_o       <= 32'd0;
            pc_o         <= 32'd0;
        end else if (jump_flag_i) begin
            // Redirect wins over a completing capture or a handshake this cycle.
            state        <= FETCH;
            pc           <= jump_addr_i;
            issue_cnt    <= 3'd0;
            recv_cnt     <= 2'd0;
            pending      <= 1'b0;
            inst_valid_o <= 1'b0;
        end else if (state == FETCH) begin
            if (mem_req_o && mem_grant_i) begin
                issue_cnt <= issue_cnt + 3'd1;
                pending   <= 1'b1;
            end else begin
                pending   <= 1'b0;
            end
            if (pending) begin
                recv_cnt <= recv_cnt + 2'd1;
                case (recv_cnt)
                    2'd0:    byte0 <= mem_din_i;
                    2'd1:    byte1 <= mem_din_i;
                    2'd2:    byte2 <= mem_din_i;
                    default: begin
                        inst_o       <= {mem_din_i, byte2, byte1, byte0};
                        pc_o         <= pc;
                        inst_valid_o <= 1'b1;
                        state        <= HOLD;
                        issue_cnt    <= 3'd0;
                    end
                endcase
            end
        end else if (inst_ready_i) begin
            inst_valid_o <= 1'b0;
            pc           <= pc + 32'd4;
            state        <= FETCH;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed vector table, hand-written corner sequences,
// and a randomized run checked by a transaction-level scoreboard.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        jump_flag = 1'b0;
    logic [31:0] jump_addr = 32'd0;
    logic        inst_ready = 1'b0;
    logic        mem_grant = 1'b0;
    logic [7:0]  mem_din = 8'd0;
    logic        mem_req, inst_valid;
    logic [31:0] mem_a, inst, pc;

    logic [7:0]  mem_din2 = 8'd0;
    logic        mem_req2, inst_valid2;
    logic [31:0] mem_a2, inst2, pc2;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    inst_fetch dut (
        .clk(clk), .rst(rst), .jump_flag_i(jump_flag), .jump_addr_i(jump_addr),
        .inst_ready_i(inst_ready), .mem_grant_i(mem_grant), .mem_din_i(mem_din),
        .mem_req_o(mem_req), .mem_a_o(mem_a), .inst_valid_o(inst_valid),
        .inst_o(inst), .pc_o(pc)
    );

    inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst(rst), .jump_flag_i(1'b0), .jump_addr_i(32'd0),
        .inst_ready_i(1'b1), .mem_grant_i(1'b1), .mem_din_i(mem_din2),
        .mem_req_o(mem_req2), .mem_a_o(mem_a2), .inst_valid_o(inst_valid2),
        .inst_o(inst2), .pc_o(pc2)
    );

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'h0: return 8'h13;  32'h1: return 8'h05;
            32'h2: return 8'h10;  32'h3: return 8'h00;
            32'h4: return 8'hB3;  32'h5: return 8'h05;
            32'h6: return 8'hB5;  32'h7: return 8'h00;
            32'h100: return 8'h6F;
            32'h101, 32'h102, 32'h103: return 8'h00;
            default: return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'hA5;
        endcase
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: the memory answers the byte granted this cycle in the next one.
    task automatic step();
        logic g1, g2;
        logic [31:0] a1, a2;
        g1 = mem_req && mem_grant;
        a1 = mem_a;
        g2 = mem_req2;
        a2 = mem_a2;
        @(posedge clk);
        #1;
        mem_din  = g1 ? mem_byte(a1) : 8'($urandom);
        mem_din2 = g2 ? mem_byte(a2) : 8'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1; jump_flag = 1'b0; mem_grant = 1'b0; inst_ready = 1'b0;
        step();
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_addr", mem_a, 32'd0);
        rst = 1'b0;
    endtask

    typedef struct {
        logic        grant, ready, jump;
        logic [31:0] jaddr;
        logic        exp_req;
        logic [31:0] exp_a;
        logic        exp_valid;
        logic [31:0] exp_inst, exp_pc;
    } vec_t;

    vec_t tbl[12];

    task automatic set_vec(input int k, input logic req, input logic [31:0] a,
                           input logic v, input logic [31:0] i, input logic [31:0] p);
        tbl[k] = '{1'b1, 1'b1, 1'b0, 32'd0, req, a, v, i, p};
    endtask

    logic [31:0] exp_pc, prev_inst, prev_pc;
    logic        prev_hold;
    int          idle;

    initial begin
        // Two back-to-back fetches from reset with grant and ready held high.
        for (int k = 0; k < 4; k++) set_vec(k, 1'b1, 32'(k), 1'b0, 32'd0, 32'd0);
        set_vec(4, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
        set_vec(5, 1'b0, 32'd0, 1'b1, 32'h0010_0513, 32'd0);
        for (int k = 6; k < 10; k++) set_vec(k, 1'b1, 32'(k - 2), 1'b0, 32'h0010_0513, 32'd0);
        set_vec(10, 1'b0, 32'd0, 1'b0, 32'h0010_0513, 32'd0);
        set_vec(11, 1'b0, 32'd0, 1'b1, 32'h00B5_05B3, 32'd4);

        do_reset();
        for (int k = 0; k < 12; k++) begin
            mem_grant = tbl[k].grant; inst_ready = tbl[k].ready;
            jump_flag = tbl[k].jump;  jump_addr  = tbl[k].jaddr;
            chk($sformatf("v%0d_req", k), 32'(mem_req), 32'(tbl[k].exp_req));
            if (tbl[k].exp_req) chk($sformatf("v%0d_addr", k), mem_a, tbl[k].exp_a);
            chk($sformatf("v%0d_valid", k), 32'(inst_valid), 32'(tbl[k].exp_valid));
            chk($sformatf("v%0d_inst", k), inst, tbl[k].exp_inst);
            chk($sformatf("v%0d_pc", k), pc, tbl[k].exp_pc);
            if (k == 5) begin
                chk("wrap_valid0", 32'(inst_valid2), 32'd1);
                chk("wrap_pc0", pc2, 32'hFFFF_FFFC);
                chk("wrap_inst0", inst2, mem_word(32'hFFFF_FFFC));
            end
            if (k == 11) begin
                chk("wrap_valid1", 32'(inst_valid2), 32'd1);
                chk("wrap_pc1", pc2, 32'd0);
                chk("wrap_inst1", inst2, 32'h0010_0513);
            end
            step();
        end

        // Grant gaps, a long stall in HOLD, then a redirect during the stall.
        do_reset();
        for (int c = 0; c < 18; c++) begin
            mem_grant = !(c == 1 || c == 2); inst_ready = 1'b0;
            jump_flag = (c == 11); jump_addr = 32'h100;
            if (c >= 1 && c <= 3) chk($sformatf("gap_addr%0d", c), mem_a, 32'd1);
            if (c == 6) chk("gap_early", 32'(inst_valid), 32'd0);
            if (c >= 7 && c <= 10) begin
                chk($sformatf("hold_valid%0d", c), 32'(inst_valid), 32'd1);
                chk($sformatf("hold_inst%0d", c), inst, 32'h0010_0513);
                chk($sformatf("hold_pc%0d", c), pc, 32'd0);
                chk($sformatf("hold_req%0d", c), 32'(mem_req), 32'd0);
            end
            if (c == 12) begin
                chk("hjmp_valid", 32'(inst_valid), 32'd0);
                chk("hjmp_req", 32'(mem_req), 32'd1);
                chk("hjmp_addr", mem_a, 32'h100);
            end
            if (c == 16) chk("hjmp_early", 32'(inst_valid), 32'd0);
            if (c == 17) begin
                chk("hjmp_v", 32'(inst_valid), 32'd1);
                chk("hjmp_inst", inst, 32'h0000_006F);
                chk("hjmp_pc", pc, 32'h100);
            end
            step();
        end

        // Redirect in the middle of a fetch.
        do_reset();
        for (int c = 0; c < 9; c++) begin
            mem_grant = 1'b1; inst_ready = 1'b0;
            jump_flag = (c == 2); jump_addr = 32'h100;
            if (c == 3) begin
                chk("jmp_req", 32'(mem_req), 32'd1);
                chk("jmp_addr", mem_a, 32'h100);
            end
            if (c == 7) chk("jmp_early", 32'(inst_valid), 32'd0);
            if (c == 8) begin
                chk("jmp_valid", 32'(inst_valid), 32'd1);
                chk("jmp_inst", inst, 32'h0000_006F);
                chk("jmp_pc", pc, 32'h100);
            end
            step();
        end
        jump_flag = 1'b0;

        // Reset in the middle of the second fetch.
        do_reset();
        mem_grant = 1'b1; inst_ready = 1'b1;
        for (int c = 0; c < 9; c++) step();
        rst = 1'b1;
        step();
        chk("mrst_valid", 32'(inst_valid), 32'd0);
        chk("mrst_inst", inst, 32'd0);
        chk("mrst_pc", pc, 32'd0);
        chk("mrst_req", 32'(mem_req), 32'd1);
        chk("mrst_addr", mem_a, 32'd0);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) step();
        chk("mrst_refetch_valid", 32'(inst_valid), 32'd1);
        chk("mrst_refetch_inst", inst, 32'h0010_0513);

        // Randomized run against a transaction-level scoreboard.
        do_reset();
        exp_pc = 32'd0; prev_hold = 1'b0; idle = 0;
        prev_inst = 32'd0; prev_pc = 32'd0;
        for (int n = 0; n < 3000; n++) begin
            mem_grant  = ($urandom_range(0, 9) < 7);
            inst_ready = $urandom_range(0, 1) == 1;
            jump_flag  = ($urandom_range(0, 29) == 0);
            jump_addr  = $urandom_range(0, 3) == 0 ? $urandom : {$urandom_range(0, 255), 2'b00};
            if (mem_req) begin
                chk("rnd_req_in_hold", 32'(inst_valid), 32'd0);
                chk("rnd_req_addr", 32'((mem_a - exp_pc) < 32'd4), 32'd1);
            end
            if (inst_valid) begin
                chk("rnd_pc", pc, exp_pc);
                chk("rnd_inst", inst, mem_word(exp_pc));
            end
            if (prev_hold)
                chk("rnd_hold_stable", 32'(inst_valid && inst == prev_inst && pc == prev_pc), 32'd1);
            prev_hold = inst_valid && !inst_ready && !jump_flag;
            prev_inst = inst; prev_pc = pc;
            idle = (inst_valid || jump_flag) ? 0 : idle + 1;
            if (idle > 100) begin
                chk("rnd_timeout", 32'(idle), 32'd0);
                break;
            end
            if (jump_flag) exp_pc = jump_addr;
            else if (inst_valid && inst_ready) exp_pc = exp_pc + 32'd4;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
